// File: rtl/seq_multiplier.sv
// Iterative unsigned shift-add multiplier: WIDTH x WIDTH -> 2*WIDTH product, one multiplier bit per clock.
// Latency: start at edge E0 gives a one-cycle done pulse in the cycle after edge E0+WIDTH (earlier with SEQ_MUL_EARLY_TERM_EN).
// Backpressure: start is honoured only while ready (IDLE or DONE); it is ignored while busy in RUN.
// Optional macro SEQ_MUL_EARLY_TERM_EN: leave RUN as soon as no multiplier bits remain set.
module seq_multiplier #(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 ready,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   out,
  output logic                 V,
  output logic                 Z
);

  localparam int               PW       = 2 * WIDTH;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [PW-1:0]     acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PW-1:0]     out_q, out_d;
  logic              v_q, v_d;
  logic              z_q, z_d;
  logic [PW-1:0]     addend;
  logic              last;

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
      v_q     <= 1'b0;
      z_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      v_q     <= v_d;
      z_q     <= z_d;
    end
  end

  // Next-state and datapath: latch operands when ready, one shift-add step per RUN cycle.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    v_d     = v_q;
    z_d     = z_q;
    addend  = '0;
    last    = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        // DONE accepts start too, so results can stream back-to-back.
        if (start) begin
          a_d     = a;
          b_d     = b;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        // Partial product for this bit position; a_q is zero-extended before shifting.
        addend = b_q[0] ? (PW'(a_q) << cnt_q) : '0;
        acc_d  = acc_q + addend;
        b_d    = b_q >> 1;
        cnt_d  = cnt_q + CNT_W'(1);
        last   = (cnt_q == LAST_CNT);
`ifdef SEQ_MUL_EARLY_TERM_EN
        // Nothing left to add once the remaining multiplier bits are all zero.
        last   = last || (b_d == '0);
`endif
        if (last) begin
          out_d   = acc_d;
          v_d     = |acc_d[PW-1:WIDTH];
          z_d     = (acc_d == '0);
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake outputs are pure state decodes; results come straight from registers.
  assign ready = (state_q == S_IDLE) || (state_q == S_DONE);
  assign busy  = (state_q == S_RUN);
  assign done  = (state_q == S_DONE);
  assign out   = out_q;
  assign V     = v_q;
  assign Z     = z_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Bench for seq_multiplier: one WIDTH=8 and one WIDTH=16 instance checked against an arithmetic model.
// Timing model: RUN lasts WIDTH cycles, or (highest set bit of b)+1 (min 1) with SEQ_MUL_EARLY_TERM_EN.
// Inputs driven and outputs sampled on the falling edge; every wait is bounded.
module tb_seq_multiplier;

  logic        clk;
  logic        rst_n;

  logic        s8, r8, bz8, d8, v8, z8;
  logic [7:0]  a8, b8;
  logic [15:0] o8;

  logic        s16, r16, bz16, d16, v16, z16;
  logic [15:0] a16, b16;
  logic [31:0] o16;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] prev8  = '0;
  logic [31:0] prev16 = '0;

  seq_multiplier #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(s8), .a(a8), .b(b8),
    .ready(r8), .busy(bz8), .done(d8), .out(o8), .V(v8), .Z(z8)
  );

  seq_multiplier #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(s16), .a(a16), .b(b16),
    .ready(r16), .busy(bz16), .done(d16), .out(o16), .V(v16), .Z(z16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected number of RUN cycles for multiplier b on a w-bit unit.
  function automatic int exp_lat(input int w, input logic [15:0] b);
    int hi;
    hi = 0;
`ifdef SEQ_MUL_EARLY_TERM_EN
    for (int i = 0; i < w; i++) if (b[i]) hi = i;
    return hi + 1;
`else
    hi = w;
    return hi;
`endif
  endfunction

  task automatic drive(input bit wide, input logic [15:0] a, input logic [15:0] b, input logic s);
    if (wide) begin a16 = a; b16 = b; s16 = s; end
    else begin a8 = a[7:0]; b8 = b[7:0]; s8 = s; end
  endtask

  task automatic sample(input bit wide, output logic dn, output logic bs, output logic rd,
                        output logic v, output logic z, output logic [31:0] o);
    if (wide) begin dn = d16; bs = bz16; rd = r16; v = v16; z = z16; o = o16; end
    else begin dn = d8; bs = bz8; rd = r8; v = v8; z = z8; o = {16'h0, o8}; end
  endtask

  // Present operands with start high; returns at the first falling edge after acceptance.
  task automatic launch(input bit wide, input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    drive(wide, a, b, 1'b1);
    @(negedge clk);
  endtask

  // Follow one operation from its first RUN cycle to done, scrambling inputs while busy.
  task automatic wait_done(input bit wide, input string tag, input logic [15:0] a, input logic [15:0] b,
                           input bit b2b, input logic [15:0] na, input logic [15:0] nb);
    int          w;
    int          lat;
    int          n;
    int          bad;
    logic [31:0] prod;
    logic [31:0] prev;
    logic        dn, bs, rd, v, z;
    logic [31:0] o;
    w    = wide ? 16 : 8;
    prod = 32'(a) * 32'(b);
    lat  = exp_lat(w, b);
    prev = wide ? prev16 : prev8;
    n    = 0;
    bad  = 0;
    sample(wide, dn, bs, rd, v, z, o);
    while (!dn && n < 100) begin
      if (bs !== 1'b1 || rd !== 1'b0 || o !== prev) bad++;
      drive(wide, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
      @(negedge clk);
      n++;
      sample(wide, dn, bs, rd, v, z, o);
    end
    chk({tag, "_done_seen"}, 32'(dn), 32'd1);
    chk({tag, "_run_cycles"}, n, lat);
    chk({tag, "_busy_hold"}, bad, 0);
    chk({tag, "_out"}, o, prod);
    chk({tag, "_V"}, 32'(v), 32'((prod >> w) != 0));
    chk({tag, "_Z"}, 32'(z), 32'(prod == 0));
    chk({tag, "_ready"}, 32'(rd), 32'd1);
    chk({tag, "_busy"}, 32'(bs), 32'd0);
    if (wide) prev16 = prod; else prev8 = prod;
    if (b2b) begin
      drive(wide, na, nb, 1'b1);
      @(negedge clk);
      drive(wide, 16'($urandom), 16'($urandom), 1'b1);
    end else begin
      drive(wide, 16'h0, 16'h0, 1'b0);
      @(negedge clk);
      sample(wide, dn, bs, rd, v, z, o);
      chk({tag, "_pulse_end"}, 32'(dn), 32'd0);
      chk({tag, "_idle_ready"}, 32'(rd), 32'd1);
      chk({tag, "_idle_out"}, o, prod);
    end
  endtask

  initial begin
    logic [15:0] ra, rb;
    rst_n = 1'b0;
    drive(1'b0, 16'h0, 16'h0, 1'b0);
    drive(1'b1, 16'h0, 16'h0, 1'b0);
    #12;
    chk("rst_ready", 32'(r8), 32'd1);
    chk("rst_busy", 32'(bz8), 32'd0);
    chk("rst_done", 32'(d8), 32'd0);
    chk("rst_out", 32'(o8), 32'd0);
    chk("rst_V", 32'(v8), 32'd0);
    chk("rst_Z", 32'(z8), 32'd0);
    chk("rst_out16", o16, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    launch(1'b0, 16'd13, 16'd11);
    wait_done(1'b0, "m13x11", 16'd13, 16'd11, 1'b0, 16'h0, 16'h0);
    launch(1'b0, 16'd255, 16'd255);
    wait_done(1'b0, "m255x255", 16'd255, 16'd255, 1'b0, 16'h0, 16'h0);
    launch(1'b0, 16'd0, 16'd200);
    wait_done(1'b0, "m0x200", 16'd0, 16'd200, 1'b0, 16'h0, 16'h0);

    // Abort an operation mid-RUN; results must clear at once, without a clock edge.
    launch(1'b0, 16'd200, 16'd100);
    @(negedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_out", 32'(o8), 32'd0);
    chk("abort_V", 32'(v8), 32'd0);
    chk("abort_Z", 32'(z8), 32'd0);
    chk("abort_done", 32'(d8), 32'd0);
    chk("abort_ready", 32'(r8), 32'd1);
    chk("abort_busy", 32'(bz8), 32'd0);
    prev8  = '0;
    prev16 = '0;
    drive(1'b0, 16'h0, 16'h0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    launch(1'b0, 16'd77, 16'd199);
    wait_done(1'b0, "after_abort", 16'd77, 16'd199, 1'b0, 16'h0, 16'h0);

    // Back-to-back: new operands accepted in the DONE cycle.
    launch(1'b0, 16'd16, 16'd16);
    wait_done(1'b0, "b2b_first", 16'd16, 16'd16, 1'b1, 16'd3, 16'd5);
    wait_done(1'b0, "b2b_second", 16'd3, 16'd5, 1'b0, 16'h0, 16'h0);

    // Timing depends on the highest set multiplier bit only in the early-exit build.
    launch(1'b0, 16'd5, 16'd1);
    wait_done(1'b0, "et5x1", 16'd5, 16'd1, 1'b0, 16'h0, 16'h0);
    launch(1'b0, 16'd99, 16'd0);
    wait_done(1'b0, "et99x0", 16'd99, 16'd0, 1'b0, 16'h0, 16'h0);
    launch(1'b1, 16'hFFFF, 16'h8000);
    wait_done(1'b1, "w16_ffff_8000", 16'hFFFF, 16'h8000, 1'b0, 16'h0, 16'h0);
    launch(1'b1, 16'hFFFF, 16'hFFFF);
    wait_done(1'b1, "w16_ffff_ffff", 16'hFFFF, 16'hFFFF, 1'b0, 16'h0, 16'h0);

    for (int i = 0; i < 30; i++) begin
      ra = 16'($urandom_range(0, 255));
      rb = 16'($urandom_range(0, 255)) >> $urandom_range(0, 8);
      launch(1'b0, ra, rb);
      wait_done(1'b0, "rand8", ra, rb, 1'b0, 16'h0, 16'h0);
    end
    for (int i = 0; i < 10; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom) >> $urandom_range(0, 16);
      launch(1'b1, ra, rb);
      wait_done(1'b1, "rand16", ra, rb, 1'b0, 16'h0, 16'h0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
